spart_msg_framer: RTL and testbench
===================================

# spart_msg_framer

Parametrised message framer between the byte-level spart engine and board logic. Packs NBYTES received bytes into one message word with a valid/ack handshake and overrun detection. Serialises one message word into NBYTES byte strobes under spart's tbr flow control. Generalises the fixed 24-bit packer with:
- configurable width;
- held RX data and acknowledge;
- a TX ready handshake;
- optional inter-byte timeout resync.

## Interface
Parameters:
- NBYTES, 3, bytes per message (>= 2); message width MW = 8*NBYTES
- TIMEOUT_CYC, 50000, idle clk cycles between RX bytes before a partial message is discarded (>= 2)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- send_tx  input  1  request to send tx_data; accepted only when tx_ready=1
- tx_data  input  MW  message to send, byte 0 = tx_data[7:0]
- tx_ready  output  1  framer idle, can accept send_tx
- rx_data  output  MW  last complete message, byte 0 in [7:0]
- rx_valid  output  1  rx_data holds an unacknowledged message
- rx_ack  input  1  consumer acknowledge, clears rx_valid
- rx_overrun  output  1  sticky: a message completed while rx_valid=1 and not acked
- rx_timeout  output  1  one-cycle pulse when a partial message is discarded
- byte_tx  output  8  byte to spart
- send_tx_byte  output  1  spart byte send strobe
- tbr  input  1  spart transmit buffer ready
- byte_rx  input  8  byte from spart
- rda  input  1  spart received-data-available strobe, one cycle per byte

## Operation
TX FSM, states IDLE and SEND:
- IDLE: tx_ready=1. A cycle with send_tx=1 loads the shift register with tx_data, sets the byte count to NBYTES and moves to SEND.
- send_tx is ignored while in SEND. The message is neither queued nor corrupted.
- SEND: tx_ready=0. byte_tx is shift[7:0]. send_tx_byte = tbr (combinational, SEND only).
- Each cycle with send_tx_byte=1: shift right 8 and decrement the count. On the strobe for the last byte, return to IDLE.
- Bytes go out LSB-first.
- Contract: spart drops tbr the cycle after a strobe.

RX assembly:
- Each rda shifts byte_rx into the top of the shift register ({byte_rx, sr[MW-1:8]}) and increments the byte count.
- On the rda of byte NBYTES:
  - If rx_valid=0, or rx_ack=1 in the same cycle: rx_data <= assembled word and rx_valid <= 1.
  - Otherwise: the new message is dropped, rx_data is unchanged and rx_overrun <= 1.
  - The byte count clears in both cases.
- rx_ack=1 with rx_valid=1 clears rx_valid and rx_overrun next cycle, unless a message completes in the same cycle (see above).
- rx_ack with rx_valid=0 has no effect.

## Timing
- Reset values: tx_ready=1, send_tx_byte=0, byte_tx=8'h00, rx_data=0, rx_valid=0, rx_overrun=0, rx_timeout=0. FSM in IDLE; counts and shift registers zero.
- Reset mid-message discards the partial RX message and aborts TX. No further send_tx_byte after reset.
- TX: send_tx accepted at edge N. tx_ready=0 and SEND from N+1. The first send_tx_byte can occur in cycle N+1 if tbr=1.
- TX: tx_ready returns to 1 the cycle after the last strobe. A new send_tx can be accepted in that same cycle.
- RX: last rda sampled at edge N gives rx_valid=1 and new rx_data visible after edge N.
- Counter widths: $clog2(NBYTES+1) for the byte counts, $clog2(TIMEOUT_CYC) for the idle counter. No wrap: the counts clear on completion or timeout.

## Configuration
Macro: SPART_FRAME_TIMEOUT_EN.

Defined:
- The idle counter runs only while the RX byte count is 1..NBYTES-1. It clears on every rda.
- When it reaches TIMEOUT_CYC-1 without an rda, the byte count and idle counter clear and rx_timeout pulses high for exactly one cycle.
- rda in the same cycle as expiry wins: the byte is accepted, there is no timeout pulse, and the idle counter clears.

Undefined:
- No idle counter. rx_timeout is tied 0.
- A partial message waits indefinitely.

## Test plan
Bench parameters: NBYTES=3, TIMEOUT_CYC=16, tbr held 1 except where noted.
- Reset, then send_tx with tx_data=24'hC3B2A1.
  - Expect byte_tx 8'hA1, 8'hB2, 8'hC3 on 3 strobes, in cycles N+1..N+3.
  - Expect tx_ready=0 from N+1 and back to 1 at N+4.
- Gated TX: tbr low for 10 cycles between bytes, with send_tx pulsed mid-message using tx_data=24'hFFFFFF.
  - Expect no strobes while tbr is low.
  - Expect the original bytes only. The second request is ignored.
- RX: rda with bytes 8'h11, 8'h22, 8'h33.
  - Expect rx_valid=1 and rx_data=24'h332211 one cycle after the third rda.
  - Hold rx_ack=0: rx_valid stays 1 and rx_data is stable.
- Overrun: with rx_valid=1 unacked, receive 8'h44, 8'h55, 8'h66.
  - Expect rx_overrun=1 and rx_data still 24'h332211.
  - Pulse rx_ack: rx_valid=0 and rx_overrun=0.
  - Repeat with rx_ack on the completing cycle: rx_data=24'h665544, rx_valid=1, no overrun.
- Timeout (macro defined): one rda of 8'hAA, then 16 idle cycles.
  - Expect a single-cycle rx_timeout.
  - Then bytes 01, 02, 03 give rx_data=24'h030201.
  - With the macro undefined, expect no pulse and rx_data=24'h0201AA.
- Reset asserted after 2 of 3 RX bytes and mid-TX: all outputs return to reset values. The next 3 bytes form a clean message.

Source files
------------

// File: rtl/spart_msg_framer.sv
// spart_msg_framer: packs NBYTES spart bytes into one message word and serialises words back out.
// Define SPART_FRAME_TIMEOUT_EN to discard partial RX messages after TIMEOUT_CYC idle cycles.
module spart_msg_framer #(
   parameter int NBYTES      = 3,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_send_tx,
   input  logic [8*NBYTES-1:0]   i_tx_data,
   output logic                  o_tx_ready,
   output logic [8*NBYTES-1:0]   o_rx_data,
   output logic                  o_rx_valid,
   input  logic                  i_rx_ack,
   output logic                  o_rx_overrun,
   output logic                  o_rx_timeout,
   output logic [7:0]            o_byte_tx,
   output logic                  o_send_tx_byte,
   input  logic                  i_tbr,
   input  logic [7:0]            i_byte_rx,
   input  logic                  i_rda
);
   localparam int MW = 8 * NBYTES;
   localparam int CW = $clog2(NBYTES + 1);

   if (NBYTES < 2 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("spart_msg_framer: NBYTES and TIMEOUT_CYC must both be >= 2");
   end

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t           r_state;
   logic [MW-1:0]    r_tx_sr;
   logic [CW-1:0]    r_tx_cnt;
   logic             r_tx_ready;
   logic             w_tx_stb;

   assign w_tx_stb       = (r_state == S_SEND) && i_tbr;
   assign o_send_tx_byte = w_tx_stb;
   assign o_byte_tx      = r_tx_sr[7:0];
   assign o_tx_ready     = r_tx_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_tx_sr    <= '0;
         r_tx_cnt   <= '0;
         r_tx_ready <= 1'b1;
      end else if (r_state == S_IDLE) begin
         if (i_send_tx) begin
            r_state    <= S_SEND;
            r_tx_sr    <= i_tx_data;
            r_tx_cnt   <= CW'(NBYTES);
            r_tx_ready <= 1'b0;
         end
      end else if (w_tx_stb) begin
         r_tx_sr  <= r_tx_sr >> 8;
         r_tx_cnt <= r_tx_cnt - CW'(1);
         if (r_tx_cnt == CW'(1)) begin
            r_state    <= S_IDLE;
            r_tx_ready <= 1'b1;
         end
      end
   end

   // RX bytes enter at the top, so after NBYTES shifts byte 0 sits in [7:0]
   logic [MW-9:0]    r_rx_sr;
   logic [MW-1:0]    r_rx_data;
   logic [MW-1:0]    w_rx_word;
   logic [CW-1:0]    r_rx_cnt;
   logic             r_rx_valid;
   logic             r_rx_overrun;
   logic             r_rx_timeout;
   logic             w_rx_last;
   logic             w_expire;

   assign w_rx_word    = {i_byte_rx, r_rx_sr};
   assign w_rx_last    = i_rda && (r_rx_cnt == CW'(NBYTES - 1));
   assign o_rx_data    = r_rx_data;
   assign o_rx_valid   = r_rx_valid;
   assign o_rx_overrun = r_rx_overrun;
   assign o_rx_timeout = r_rx_timeout;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_sr      <= '0;
         r_rx_data    <= '0;
         r_rx_cnt     <= '0;
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
         r_rx_timeout <= 1'b0;
      end else begin
         r_rx_timeout <= w_expire;
         if (i_rda) begin
            r_rx_sr  <= w_rx_word[MW-1:8];
            r_rx_cnt <= w_rx_last ? '0 : r_rx_cnt + CW'(1);
         end else if (w_expire) begin
            r_rx_cnt <= '0;
         end
         if (w_rx_last && (!r_rx_valid || i_rx_ack)) begin
            r_rx_data    <= w_rx_word;
            r_rx_valid   <= 1'b1;
            r_rx_overrun <= 1'b0;
         end else if (w_rx_last) begin
            r_rx_overrun <= 1'b1;
         end else if (i_rx_ack) begin
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
         end
      end
   end

`ifdef SPART_FRAME_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC);
   logic [TW-1:0]    r_idle;

   // an rda arriving on the expiry cycle keeps the partial message alive
   assign w_expire = (r_rx_cnt != '0) && !i_rda && (r_idle == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge i_clk) begin
      r_idle <= (i_rst || i_rda || w_expire || r_rx_cnt == '0) ? '0 : r_idle + TW'(1);
   end
`else
   assign w_expire = 1'b0;
`endif

endmodule

// File: tb/tb_spart_msg_framer.sv
// tb_spart_msg_framer: directed table, corner sequences and random traffic against a queue-based model.
module tb_spart_msg_framer;
   localparam int NB = 3;
   localparam int TO = 16;
   localparam int MW = 8 * NB;
`ifdef SPART_FRAME_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          send_tx = 1'b0;
   logic [MW-1:0] tx_data = '0;
   logic          tbr = 1'b1;
   logic          rda = 1'b0;
   logic [7:0]    byte_rx = '0;
   logic          rx_ack = 1'b0;
   logic          o_tx_ready, o_rx_valid, o_rx_overrun, o_rx_timeout, o_send_tx_byte;
   logic [MW-1:0] o_rx_data;
   logic [7:0]    o_byte_tx;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   spart_msg_framer #(.NBYTES(NB), .TIMEOUT_CYC(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_send_tx(send_tx), .i_tx_data(tx_data),
      .o_tx_ready(o_tx_ready), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
      .i_rx_ack(rx_ack), .o_rx_overrun(o_rx_overrun), .o_rx_timeout(o_rx_timeout),
      .o_byte_tx(o_byte_tx), .o_send_tx_byte(o_send_tx_byte), .i_tbr(tbr),
      .i_byte_rx(byte_rx), .i_rda(rda)
   );

   // reference model: pending TX bytes and received RX bytes as queues
   logic [7:0]    tx_q[$];
   logic [7:0]    rx_q[$];
   logic [MW-1:0] m_data = '0;
   logic          m_valid = 1'b0;
   logic          m_ovr = 1'b0;
   logic          m_to = 1'b0;
   int            m_idle = 0;
   logic [7:0]    got[$];
   int            stb_low = 0;
   int            to_pulses = 0;

   typedef struct {
      logic rst, send; logic [MW-1:0] txd; logic tbr, rda; logic [7:0] rxb; logic ack;
      logic e_rdy, e_stb; logic [7:0] e_byte; logic e_val; logic [MW-1:0] e_data; logic e_ovr;
   } vec_t;
   vec_t vecs[$];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [MW-1:0] msg;
      if (rst) begin
         tx_q.delete(); rx_q.delete();
         m_data = '0; m_valid = 0; m_ovr = 0; m_to = 0; m_idle = 0;
         return;
      end
      if (tx_q.size() == 0) begin
         if (send_tx) for (int i = 0; i < NB; i++) tx_q.push_back(tx_data[8*i +: 8]);
      end else if (tbr) begin
         void'(tx_q.pop_front());
      end
      m_to = 0;
      if (rda) rx_q.push_back(byte_rx);
      if (rda && rx_q.size() == NB) begin
         msg = '0;
         foreach (rx_q[i]) msg[8*i +: 8] = rx_q[i];
         rx_q.delete();
         if (!m_valid || rx_ack) begin
            m_data = msg; m_valid = 1; m_ovr = 0;
         end else begin
            m_ovr = 1;
         end
      end else if (rx_ack) begin
         m_valid = 0; m_ovr = 0;
      end
      if (rda || rx_q.size() == 0) begin
         m_idle = 0;
      end else if (TO_EN) begin
         m_idle++;
         if (m_idle == TO) begin
            rx_q.delete(); m_idle = 0; m_to = 1;
         end
      end
   endtask

   task automatic check_model();
      logic [7:0] eb;
      eb = 8'h00;
      if (tx_q.size() != 0) eb = tx_q[0];
      cmp("tx_ready", o_tx_ready, tx_q.size() == 0);
      cmp("send_tx_byte", o_send_tx_byte, tx_q.size() != 0 && tbr);
      cmp("byte_tx", o_byte_tx, eb);
      cmp("rx_data", o_rx_data, m_data);
      cmp("rx_valid", o_rx_valid, m_valid);
      cmp("rx_overrun", o_rx_overrun, m_ovr);
      cmp("rx_timeout", o_rx_timeout, m_to);
      if (o_send_tx_byte) begin
         got.push_back(o_byte_tx);
         if (!tbr) stb_low++;
      end
      if (o_rx_timeout) to_pulses++;
   endtask

   task automatic tick();
      #1 check_model();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic rtick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic v(input logic r, s, input logic [MW-1:0] d, input logic t, a, input logic [7:0] b,
                    input logic k, er, es, input logic [7:0] eb, input logic ev,
                    input logic [MW-1:0] ed, input logic eo);
      vecs.push_back('{r, s, d, t, a, b, k, er, es, eb, ev, ed, eo});
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rda = 1'b1; byte_rx = b; tick(); rda = 1'b0;
   endtask

   initial begin
      logic [MW-1:0] w;
      // rst send txd tbr rda rxb ack | rdy stb byte val data ovr  (outputs seen before the row's edge)
      v(0, 0, 24'h0,      1, 0, 8'h00, 0,  1, 0, 8'h00, 0, 24'h0,      0);
      v(0, 1, 24'hC3B2A1, 1, 0, 8'h00, 0,  1, 0, 8'h00, 0, 24'h0,      0);
      v(0, 0, 24'h0,      1, 0, 8'h00, 0,  0, 1, 8'hA1, 0, 24'h0,      0);
      v(0, 0, 24'h0,      1, 0, 8'h00, 0,  0, 1, 8'hB2, 0, 24'h0,      0);
      v(0, 0, 24'h0,      1, 0, 8'h00, 0,  0, 1, 8'hC3, 0, 24'h0,      0);
      v(0, 0, 24'h0,      1, 1, 8'h11, 0,  1, 0, 8'h00, 0, 24'h0,      0);
      v(0, 0, 24'h0,      1, 1, 8'h22, 0,  1, 0, 8'h00, 0, 24'h0,      0);
      v(0, 0, 24'h0,      1, 1, 8'h33, 0,  1, 0, 8'h00, 0, 24'h0,      0);
      v(0, 0, 24'h0,      1, 0, 8'h00, 0,  1, 0, 8'h00, 1, 24'h332211, 0);
      v(0, 0, 24'h0,      1, 0, 8'h00, 0,  1, 0, 8'h00, 1, 24'h332211, 0);
      v(0, 0, 24'h0,      1, 1, 8'h44, 0,  1, 0, 8'h00, 1, 24'h332211, 0);
      v(0, 0, 24'h0,      1, 1, 8'h55, 0,  1, 0, 8'h00, 1, 24'h332211, 0);
      v(0, 0, 24'h0,      1, 1, 8'h66, 0,  1, 0, 8'h00, 1, 24'h332211, 0);
      v(0, 0, 24'h0,      1, 0, 8'h00, 1,  1, 0, 8'h00, 1, 24'h332211, 1);
      v(0, 0, 24'h0,      1, 1, 8'h77, 0,  1, 0, 8'h00, 0, 24'h332211, 0);
      v(0, 0, 24'h0,      1, 1, 8'h88, 0,  1, 0, 8'h00, 0, 24'h332211, 0);
      v(0, 0, 24'h0,      1, 1, 8'h99, 0,  1, 0, 8'h00, 0, 24'h332211, 0);
      v(0, 0, 24'h0,      1, 1, 8'h44, 0,  1, 0, 8'h00, 1, 24'h998877, 0);
      v(0, 0, 24'h0,      1, 1, 8'h55, 0,  1, 0, 8'h00, 1, 24'h998877, 0);
      v(0, 0, 24'h0,      1, 1, 8'h66, 1,  1, 0, 8'h00, 1, 24'h998877, 0);
      v(0, 0, 24'h0,      1, 0, 8'h00, 0,  1, 0, 8'h00, 1, 24'h665544, 0);

      rtick(); rtick();
      foreach (vecs[i]) begin
         rst = vecs[i].rst; send_tx = vecs[i].send; tx_data = vecs[i].txd; tbr = vecs[i].tbr;
         rda = vecs[i].rda; byte_rx = vecs[i].rxb; rx_ack = vecs[i].ack;
         #1;
         cmp($sformatf("v%0d_ready", i), o_tx_ready, vecs[i].e_rdy);
         cmp($sformatf("v%0d_stb", i), o_send_tx_byte, vecs[i].e_stb);
         cmp($sformatf("v%0d_byte", i), o_byte_tx, vecs[i].e_byte);
         cmp($sformatf("v%0d_valid", i), o_rx_valid, vecs[i].e_val);
         cmp($sformatf("v%0d_data", i), o_rx_data, vecs[i].e_data);
         cmp($sformatf("v%0d_ovr", i), o_rx_overrun, vecs[i].e_ovr);
         tick();
      end
      rst = 0; send_tx = 0; rda = 0; rx_ack = 0; tbr = 1;

      // gated TX with a second request arriving mid-message
      got.delete(); stb_low = 0;
      send_tx = 1; tx_data = 24'h0A0B0C; tick();
      send_tx = 0; tick();
      tbr = 0;
      for (int i = 0; i < 10; i++) begin
         send_tx = (i == 4); tx_data = (i == 4) ? 24'hFFFFFF : 24'h0A0B0C; tick();
      end
      send_tx = 0; tbr = 1; tick();
      tbr = 0; repeat (5) tick();
      tbr = 1; tick();
      tick();
      w = '0;
      foreach (got[i]) if (i < NB) w[8*i +: 8] = got[i];
      cmp("gated_count", got.size(), NB);
      cmp("gated_bytes", w, 24'h0A0B0C);
      cmp("gated_stb_low", stb_low, 0);
      cmp("gated_ready", o_tx_ready, 1'b1);

      // inter-byte timeout
      rx_ack = 1; tick(); rx_ack = 0;
      to_pulses = 0;
      rx_byte(8'hAA);
      repeat (16) tick();
      rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03);
      tick();
      cmp("to_pulses", to_pulses, TO_EN ? 1 : 0);
      cmp("to_data", o_rx_data, TO_EN ? 24'h030201 : 24'h0201AA);

      // reset mid-RX and mid-TX
      rst = 1; tick(); rst = 0;
      rx_byte(8'h01); rx_byte(8'h02);
      send_tx = 1; tx_data = 24'h112233; tick();
      send_tx = 0; tick();
      rst = 1; tick(); rst = 0; tbr = 1;
      #1;
      cmp("rst_ready", o_tx_ready, 1'b1);
      cmp("rst_stb", o_send_tx_byte, 1'b0);
      cmp("rst_byte", o_byte_tx, 8'h00);
      cmp("rst_valid", o_rx_valid, 1'b0);
      cmp("rst_data", o_rx_data, 24'h0);
      cmp("rst_ovr", o_rx_overrun, 1'b0);
      cmp("rst_to", o_rx_timeout, 1'b0);
      rx_byte(8'h44); rx_byte(8'h55); rx_byte(8'h66);
      tick();
      cmp("rst_msg_data", o_rx_data, 24'h665544);
      cmp("rst_msg_valid", o_rx_valid, 1'b1);

      // rda landing exactly on the expiry cycle keeps the partial message
      rx_ack = 1; tick(); rx_ack = 0;
      to_pulses = 0;
      rx_byte(8'hBB);
      repeat (15) tick();
      rx_byte(8'hCC); rx_byte(8'hDD);
      tick();
      cmp("edge_pulses", to_pulses, 0);
      cmp("edge_data", o_rx_data, 24'hDDCCBB);

      // random traffic, sparse rda in the second half so timeouts occur
      for (int i = 0; i < 4000; i++) begin
         rst     = ($urandom_range(0, 299) == 0);
         send_tx = ($urandom_range(0, 3) == 0);
         tx_data = MW'($urandom);
         tbr     = 1'($urandom_range(0, 1));
         rda     = (i < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
         byte_rx = 8'($urandom);
         rx_ack  = ($urandom_range(0, 7) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
